// File: rtl/sevenseg_scan_driver.sv
// N-digit multiplexed hex seven-segment driver with a loadable, auto-incrementing display register.
// seg/dp/an/frame are registered, one clock after digit_idx/disp_reg; there is no backpressure.
module sevenseg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int STEP_DIV    = 50000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  input  logic                    count_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int SW = $clog2(STEP_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] STEP_LAST    = SW'(STEP_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_DIGITS - 1);

  logic [RW-1:0]         refresh_cnt_q, refresh_cnt_d;
  logic [SW-1:0]         step_cnt_q, step_cnt_d;
  logic [IW-1:0]         digit_idx_q, digit_idx_d;
  logic [DW-1:0]         disp_reg_q, disp_reg_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_q, frame_d;

  logic [3:0]            cur_nib;
  logic                  cur_blank;
  logic                  zero_run;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'h7E;
      4'h1:    s = 7'h30;
      4'h2:    s = 7'h6D;
      4'h3:    s = 7'h79;
      4'h4:    s = 7'h33;
      4'h5:    s = 7'h5B;
      4'h6:    s = 7'h5F;
      4'h7:    s = 7'h70;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h7B;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h1F;
      4'hC:    s = 7'h4E;
      4'hD:    s = 7'h3D;
      4'hE:    s = 7'h4F;
      default: s = 7'h47;
    endcase
    return s;
  endfunction

  always_comb begin
    refresh_cnt_d = refresh_cnt_q + RW'(1);
    digit_idx_d   = digit_idx_q;
    frame_d       = 1'b0;
    if (refresh_cnt_q == REFRESH_LAST) begin
      refresh_cnt_d = '0;
      if (digit_idx_q == IDX_LAST) begin
        digit_idx_d = '0;
        frame_d     = 1'b1;
      end else begin
        digit_idx_d = digit_idx_q + IW'(1);
      end
    end

    // step_cnt simply holds while count_en is low
    step_cnt_d = step_cnt_q;
    disp_reg_d = disp_reg_q;
    if (count_en) begin
      if (step_cnt_q == STEP_LAST) begin
        step_cnt_d = '0;
        disp_reg_d = disp_reg_q + DW'(1);
      end else begin
        step_cnt_d = step_cnt_q + SW'(1);
      end
    end
    if (load) begin
      disp_reg_d = value;
      step_cnt_d = '0;
    end

    // Walk from the top digit down so zero_run means "this nibble and all above are zero"
    cur_nib   = 4'h0;
    cur_blank = 1'b0;
    zero_run  = 1'b1;
    dp_d      = 1'b0;
    an_d      = '1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (disp_reg_q[4*k +: 4] == 4'h0);
      if (digit_idx_q == IW'(k)) begin
        cur_nib   = disp_reg_q[4*k +: 4];
        cur_blank = blank_lz & zero_run & (k != 0);
        dp_d      = dp_in[k];
        an_d[k]   = 1'b0;
      end
    end
    seg_d = cur_blank ? 7'h00 : hex2seg(cur_nib);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt_q <= '0;
      step_cnt_q    <= '0;
      digit_idx_q   <= '0;
      disp_reg_q    <= '0;
      seg_q         <= 7'h00;
      dp_q          <= 1'b0;
      an_q          <= '1;
      frame_q       <= 1'b0;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      step_cnt_q    <= step_cnt_d;
      digit_idx_q   <= digit_idx_d;
      disp_reg_q    <= disp_reg_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      frame_q       <= frame_d;
    end
  end

  assign seg   = seg_q;
  assign dp    = dp_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule
